// File: rtl/mac_seq_ctrl_if.sv
// Handshake bundle between layer control, the chunk store, macfp and mac_seq_ctrl.
// master = sequencer view, slave = environment view (layer control + store + macfp).
interface mac_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int N      = 2,
    parameter int NCHUNK = 4
);
    localparam int CIW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic                 go;
    logic [2*WIDTH-1:0]   bias;
    logic                 busy;
    logic [CIW-1:0]       chunk_idx;
    logic [N*WIDTH-1:0]   x_vec;
    logic [N*WIDTH-1:0]   w_vec;
    logic [N*WIDTH-1:0]   mac_a;
    logic [N*WIDTH-1:0]   mac_b;
    logic                 mac_start;
    logic                 mac_ack;
    logic                 mac_done;
    logic [2*WIDTH-1:0]   mac_acc;
    logic [2*WIDTH-1:0]   y;
    logic                 y_valid;

    modport master (
        input  go, bias, x_vec, w_vec, mac_ack, mac_done, mac_acc,
        output busy, chunk_idx, mac_a, mac_b, mac_start, y, y_valid
    );

    modport slave (
        output go, bias, x_vec, w_vec, mac_ack, mac_done, mac_acc,
        input  busy, chunk_idx, mac_a, mac_b, mac_start, y, y_valid
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Neuron sequencer: fetches NCHUNK operand chunks, runs one macfp 4-phase transaction each, saturates.
// Latency go->y_valid = 2 + sum per chunk (LOAD + REQ + WAIT + REL), each >= 1 cycle.
// Backpressure: stalls in REQ/WAIT/REL on macfp; go ignored while busy. RELU_EN clamps negatives to 0.
module mac_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int N      = 2,
    parameter int NCHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.master bus
);
    localparam int CIW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int ACCW = 2*WIDTH + $clog2(NCHUNK) + 1;
    localparam int EXTW = ACCW - 2*WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, REL, FIN} state_t;

    state_t             state;
    logic [ACCW-1:0]    acc;
    logic [2*WIDTH-1:0] sat_val;

    // Out of range whenever the bits above the result's sign bit disagree with acc's sign.
    always_comb begin
        sat_val = acc[2*WIDTH-1:0];
        if (acc[ACCW-1:2*WIDTH-1] != {(EXTW+1){acc[ACCW-1]}}) begin
            sat_val = acc[ACCW-1] ? {1'b1, {(2*WIDTH-1){1'b0}}}
                                  : {1'b0, {(2*WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            acc           <= '0;
            bus.busy      <= 1'b0;
            bus.chunk_idx <= '0;
            bus.mac_a     <= '0;
            bus.mac_b     <= '0;
            bus.mac_start <= 1'b0;
            bus.y         <= '0;
            bus.y_valid   <= 1'b0;
        end else begin
            bus.y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        acc           <= {{EXTW{bus.bias[2*WIDTH-1]}}, bus.bias};
                        bus.chunk_idx <= '0;
                        bus.busy      <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    bus.mac_a     <= bus.x_vec;
                    bus.mac_b     <= bus.w_vec;
                    bus.mac_start <= 1'b1;
                    state         <= REQ;
                end
                // A done seen together with ack is left for WAIT; macfp holds it until start drops.
                REQ: begin
                    if (bus.mac_ack) begin
                        bus.mac_start <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mac_done) begin
                        acc   <= acc + {{EXTW{bus.mac_acc[2*WIDTH-1]}}, bus.mac_acc};
                        state <= REL;
                    end
                end
                REL: begin
                    if (!bus.mac_done) begin
                        if (bus.chunk_idx == CIW'(NCHUNK-1)) begin
                            state <= FIN;
                        end else begin
                            bus.chunk_idx <= bus.chunk_idx + CIW'(1);
                            state         <= LOAD;
                        end
                    end
                end
                FIN: begin
`ifdef RELU_EN
                    bus.y <= sat_val[2*WIDTH-1] ? '0 : sat_val;
`else
                    bus.y <= sat_val;
`endif
                    bus.y_valid <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a macfp responder and a combinational chunk store.
module tb_mac_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] resp_acc = 16'h0000;
    bit          fast = 1'b0;
    int          rs = 0;
    int          ns = 0;
    int          yv_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic        prev_start = 1'b0;

    mac_seq_ctrl_if #(.WIDTH(8), .N(2), .NCHUNK(4)) bus ();

    mac_seq_ctrl #(.WIDTH(8), .N(2), .NCHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.x_vec   = {8'h11 + 8'(bus.chunk_idx), 8'h01 + 8'(bus.chunk_idx)};
    assign bus.w_vec   = {8'h31 + 8'(bus.chunk_idx), 8'h21 + 8'(bus.chunk_idx)};
    assign bus.mac_acc = resp_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // macfp responder: ack 1 cycle after start, done 2 cycles after ack, done drops once start is low.
    // In fast mode ack and done rise together.
    initial begin
        bus.mac_ack  = 1'b0;
        bus.mac_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                bus.mac_ack  = 1'b0;
                bus.mac_done = 1'b0;
                rs = 0;
            end else begin
                case (rs)
                    0: if (bus.mac_start) begin
                        bus.mac_ack = 1'b1;
                        if (fast) bus.mac_done = 1'b1;
                        rs = 1;
                    end
                    1: begin
                        bus.mac_ack = 1'b0;
                        rs = fast ? 3 : 2;
                    end
                    2: begin
                        bus.mac_done = 1'b1;
                        rs = 3;
                    end
                    default: if (!bus.mac_start) begin
                        bus.mac_done = 1'b0;
                        rs = 0;
                    end
                endcase
            end
        end
    end

    // Each new request must address the next chunk and carry that chunk's operands.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (bus.mac_start && !prev_start) begin
                check("start_idx", 32'(bus.chunk_idx), ns);
                check("mac_a", 32'(bus.mac_a), 32'({8'h11 + 8'(ns), 8'h01 + 8'(ns)}));
                check("mac_b", 32'(bus.mac_b), 32'({8'h31 + 8'(ns), 8'h21 + 8'(ns)}));
                ns++;
            end
            prev_start = bus.mac_start;
            if (bus.y_valid) yv_cnt++;
        end
    end

    task automatic run_neuron(input string tag, input logic [15:0] b, input logic [15:0] macv,
                              input logic [15:0] exp_y, input bit fast_m, input bit double_go);
        int cyc;
        bus.bias = b;
        resp_acc = macv;
        fast     = fast_m;
        ns       = 0;
        yv_cnt   = 0;
        @(posedge clk); #1 bus.go = 1'b1;
        @(posedge clk); #1 bus.go = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        if (double_go) begin
            repeat (3) @(posedge clk);
            #1 bus.go = 1'b1;
            bus.bias = 16'h1234;
            @(posedge clk); #1 bus.go = 1'b0;
        end
        cyc = 0;
        while (!bus.y_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_yvalid"}, 32'(bus.y_valid), 1);
        check({tag, "_y"}, 32'(bus.y), 32'(exp_y));
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(bus.y_valid), 0);
        check({tag, "_y_hold"}, 32'(bus.y), 32'(exp_y));
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_yv_cnt"}, yv_cnt, 1);
        check({tag, "_starts"}, ns, 4);
        check({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.go   = 1'b0;
        bus.bias = 16'h0000;
        rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_start", 32'(bus.mac_start), 0);
        check("rst_yvalid", 32'(bus.y_valid), 0);
        check("rst_y", 32'(bus.y), 0);
        check("rst_idx", 32'(bus.chunk_idx), 0);
        check("rst_mac_a", 32'(bus.mac_a), 0);
        rst = 1'b1;

        run_neuron("T1", 16'h0000, 16'h0010, 16'h0040, 1'b0, 1'b0);
        run_neuron("T2", 16'h7000, 16'h7000, 16'h7FFF, 1'b0, 1'b0);
`ifdef RELU_EN
        run_neuron("T3", 16'hFF00, 16'h0000, 16'h0000, 1'b0, 1'b0);
`else
        run_neuron("T3", 16'hFF00, 16'h0000, 16'hFF00, 1'b0, 1'b0);
`endif
        run_neuron("T4", 16'h8000, 16'hC000, 16'h8000, 1'b0, 1'b0);

        // T5: reset lands while the third chunk waits for done.
        bus.bias = 16'h0000;
        resp_acc = 16'h0010;
        fast     = 1'b0;
        ns       = 0;
        yv_cnt   = 0;
        @(posedge clk); #1 bus.go = 1'b1;
        @(posedge clk); #1 bus.go = 1'b0;
        cyc = 0;
        while (!(ns == 3 && !bus.mac_start && bus.chunk_idx == 2'd2) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("T5_reach_wait", 32'(cyc < 300), 1);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        check("T5_start", 32'(bus.mac_start), 0);
        check("T5_busy", 32'(bus.busy), 0);
        check("T5_yvalid", 32'(bus.y_valid), 0);
        check("T5_idx", 32'(bus.chunk_idx), 0);
        repeat (12) @(posedge clk);
        #1;
        check("T5_no_yvalid", yv_cnt, 0);
        check("T5_idle_start", 32'(bus.mac_start), 0);
        run_neuron("T5b", 16'h0000, 16'h0010, 16'h0040, 1'b0, 1'b0);

        run_neuron("T6", 16'h0000, 16'h0010, 16'h0040, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
